// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mouse_pkg
// Brief    : Shared PS/2 mouse definitions (frame states, error codes,
//            frame geometry, default timeout) for the receive and transmit
//            paths. Optional debug counter macro: MOUSE_RX_ERR_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package mouse_pkg;

    // Frame state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP,
        DONE   = ST_DONE
    } ps2_state_t;

    // Error code bits reported alongside each byte
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    localparam int PS2_FRAME_DATA_BITS    = 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 50000;

    // Odd parity bit the device should send for a given data byte
    function automatic logic odd_parity(input logic [PS2_FRAME_DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mouse_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : mouse_receiver_if
// Brief    : PS/2 receive-side bundle: pad lines and enable in, received
//            byte with error flags and strobe out. ERROR_COUNT exists only
//            when MOUSE_RX_ERR_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface mouse_receiver_if;
    logic       CLK_MOUSE_IN;
    logic       DATA_MOUSE_IN;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
`ifdef MOUSE_RX_ERR_COUNT_EN
    logic [7:0] ERROR_COUNT;
`endif

    // Receiver side
    modport slave (
        input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
`ifdef MOUSE_RX_ERR_COUNT_EN
        output ERROR_COUNT,
`endif
        output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );

    // Pad / consumer side
    modport master (
        output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
`ifdef MOUSE_RX_ERR_COUNT_EN
        input  ERROR_COUNT,
`endif
        input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );
endinterface
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sync_edge
// Brief    : Two-flop synchroniser for an asynchronous PS/2 pad line with an
//            optional one-cycle falling-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_sync_edge #(
    parameter bit EDGE_EN = 1'b1
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic async_i,
    output logic      sync_o,
    output logic      fall_o
);
    logic meta_q;
    logic sync_q;

    // Two-stage synchroniser; lines idle high so reset to 1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;

            // Previous synchronised value for falling-edge detection
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    prev_q <= 1'b1;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign fall_o = prev_q & ~sync_q;
        end else begin : g_no_edge
            assign fall_o = 1'b0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/mouse_receiver.sv
`default_nettype none
// ============================================================================
// Module   : mouse_receiver
// Brief    : PS/2 device-to-host receiver. Deframes start, 8 data bits LSB
//            first, odd parity and stop; delivers byte, error code and a
//            one-cycle ready strobe. Partial frames are abandoned after
//            TIMEOUT_CYCLES without a PS/2 clock fall.
//            Optional: MOUSE_RX_ERR_COUNT_EN adds a saturating ERROR_COUNT.
// Revision : 1.0 - initial release
// ============================================================================
module mouse_receiver
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int CTR_WIDTH      = 16
) (
    input  wire logic       CLK,
    input  wire logic       RESET,
    mouse_receiver_if.slave bus
);
    localparam int                   c_BITCTR_W = $clog2(PS2_FRAME_DATA_BITS);
    localparam logic [c_BITCTR_W-1:0] c_LAST_BIT = c_BITCTR_W'(PS2_FRAME_DATA_BITS - 1);
    localparam logic [CTR_WIDTH-1:0]  c_TMO_LAST = CTR_WIDTH'(TIMEOUT_CYCLES - 1);

    logic clk_fall;
    logic clk_sync_unused;
    logic data_sync;
    logic data_fall_unused;

    ps2_sync_edge #(.EDGE_EN(1'b1)) u_clk_sync (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .async_i (bus.CLK_MOUSE_IN),
        .sync_o  (clk_sync_unused),
        .fall_o  (clk_fall)
    );

    ps2_sync_edge #(.EDGE_EN(1'b0)) u_data_sync (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .async_i (bus.DATA_MOUSE_IN),
        .sync_o  (data_sync),
        .fall_o  (data_fall_unused)
    );

    ps2_state_t                     state_q;
    logic [c_BITCTR_W-1:0]          bitctr_q;
    logic [PS2_FRAME_DATA_BITS-1:0] shift_q;
    logic                           parity_q;
    logic                           stop_q;
    logic [CTR_WIDTH-1:0]           tmo_q;
    logic [7:0]                     byte_read_q;
    logic [1:0]                     byte_err_q;
    logic                           byte_ready_q;
    logic [1:0]                     byte_err_d;
    logic                           tmo_abort;

    // Error code for the frame currently held in the shift/parity/stop regs
    assign byte_err_d = ((parity_q != odd_parity(shift_q)) ? ERR_PARITY : ERR_NONE)
                      | (stop_q ? ERR_NONE : ERR_STOP);

    // A fall always takes priority over the terminal timeout count
    assign tmo_abort = (state_q == DATA || state_q == PARITY || state_q == STOP)
                     && !clk_fall && (tmo_q == c_TMO_LAST);

    // Frame FSM with timeout counter and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            bitctr_q     <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            stop_q       <= 1'b0;
            tmo_q        <= '0;
            byte_read_q  <= 8'h00;
            byte_err_q   <= ERR_NONE;
            byte_ready_q <= 1'b0;
        end else begin
            byte_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (clk_fall && !data_sync && bus.READ_ENABLE) begin
                        state_q  <= DATA;
                        bitctr_q <= '0;
                    end
                end
                DATA, PARITY, STOP: begin
                    if (clk_fall) begin
                        tmo_q <= '0;
                        if (state_q == DATA) begin
                            shift_q[bitctr_q] <= data_sync;
                            bitctr_q          <= bitctr_q + c_BITCTR_W'(1);
                            if (bitctr_q == c_LAST_BIT) begin
                                state_q <= PARITY;
                            end
                        end else if (state_q == PARITY) begin
                            parity_q <= data_sync;
                            state_q  <= STOP;
                        end else begin
                            stop_q  <= data_sync;
                            state_q <= DONE;
                        end
                    end else if (tmo_abort) begin
                        state_q <= IDLE;
                    end else if (tmo_q != '1) begin
                        tmo_q <= tmo_q + CTR_WIDTH'(1);
                    end
                end
                DONE: begin
                    byte_read_q  <= shift_q;
                    byte_err_q   <= byte_err_d;
                    byte_ready_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.BYTE_READ       = byte_read_q;
    assign bus.BYTE_ERROR_CODE = byte_err_q;
    assign bus.BYTE_READY      = byte_ready_q;

`ifdef MOUSE_RX_ERR_COUNT_EN
    logic [7:0] errcnt_q;

    // Saturating count of errored bytes and timeout aborts
    always_ff @(posedge CLK) begin
        if (RESET) begin
            errcnt_q <= 8'h00;
        end else if (((state_q == DONE) && (byte_err_d != ERR_NONE)) || tmo_abort) begin
            if (errcnt_q != 8'hFF) begin
                errcnt_q <= errcnt_q + 8'h01;
            end
        end
    end

    assign bus.ERROR_COUNT = errcnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mouse_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_mouse_receiver
// Brief    : Directed self-checking bench for mouse_receiver with a shortened
//            PS/2 bit period and timeout. Extra ERROR_COUNT checks when
//            MOUSE_RX_ERR_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mouse_receiver;
    localparam int TMO = 300;   // timeout in CLK cycles
    localparam int Q   = 12;    // data setup / hold around the clock pulse
    localparam int H   = 25;    // PS/2 clock low time

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rdy_cnt = 0;
    int   rdy_cyc = 0;
    int   fall_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic [1:0] last_err  = 2'b00;

    mouse_receiver_if bus();

    mouse_receiver #(
        .TIMEOUT_CYCLES (TMO),
        .CTR_WIDTH      (16)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle the strobe is seen high
    always @(negedge clk) begin
        if (bus.BYTE_READY === 1'b1) begin
            rdy_cnt   = rdy_cnt + 1;
            rdy_cyc   = cyc;
            last_byte = bus.BYTE_READ;
            last_err  = bus.BYTE_ERROR_CODE;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        bus.DATA_MOUSE_IN = b;
        tick(Q);
        bus.CLK_MOUSE_IN = 1'b0;
        fall_cyc = cyc;
        tick(H);
        bus.CLK_MOUSE_IN = 1'b1;
        tick(Q);
    endtask

    task automatic send_bits(input logic [10:0] f, input int first, input int n);
        for (int i = first; i < first + n; i++) ps2_bit(f[i]);
        bus.DATA_MOUSE_IN = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(4);
        total++;
        if (bus.BYTE_READ !== 8'h00 || bus.BYTE_ERROR_CODE !== 2'b00 || bus.BYTE_READY !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: got byte=%h err=%b rdy=%b want 00/00/0",
                     bus.BYTE_READ, bus.BYTE_ERROR_CODE, bus.BYTE_READY);
        end
`ifdef MOUSE_RX_ERR_COUNT_EN
        total++;
        if (bus.ERROR_COUNT !== 8'h00) begin
            bad++;
            $display("FAIL reset_errcnt: got %h want 00", bus.ERROR_COUNT);
        end
`endif
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_basic;
        int n0 = rdy_cnt;
        send_bits(mk_frame(8'hFA, 1'b1, 1'b1), 0, 11);
        tick(20);
        total++;
        if (rdy_cnt - n0 !== 1) begin
            bad++;
            $display("FAIL fa_pulses: got %0d want 1", rdy_cnt - n0);
        end
        total++;
        if (last_byte !== 8'hFA || last_err !== 2'b00) begin
            bad++;
            $display("FAIL fa_data: got %h/%b want fa/00", last_byte, last_err);
        end
        total++;
        if (rdy_cyc - fall_cyc !== 4) begin
            bad++;
            $display("FAIL fa_latency: got %0d want 4", rdy_cyc - fall_cyc);
        end
    endtask

    task automatic test_parity_error;
        int n0 = rdy_cnt;
        send_bits(mk_frame(8'h08, 1'b1, 1'b1), 0, 11);
        tick(20);
        total++;
        if (rdy_cnt - n0 !== 1 || last_byte !== 8'h08 || last_err !== 2'b01) begin
            bad++;
            $display("FAIL parity_err: got n=%0d %h/%b want 1 08/01", rdy_cnt - n0, last_byte, last_err);
        end
`ifdef MOUSE_RX_ERR_COUNT_EN
        total++;
        if (bus.ERROR_COUNT !== 8'h01) begin
            bad++;
            $display("FAIL parity_errcnt: got %h want 01", bus.ERROR_COUNT);
        end
`endif
    endtask

    task automatic test_stop_error;
        int n0 = rdy_cnt;
        send_bits(mk_frame(8'h00, 1'b1, 1'b0), 0, 11);
        tick(20);
        total++;
        if (rdy_cnt - n0 !== 1 || last_byte !== 8'h00 || last_err !== 2'b10) begin
            bad++;
            $display("FAIL stop_err: got n=%0d %h/%b want 1 00/10", rdy_cnt - n0, last_byte, last_err);
        end
        n0 = rdy_cnt;
        send_bits(mk_frame(8'hAA, 1'b1, 1'b1), 0, 11);
        tick(20);
        total++;
        if (rdy_cnt - n0 !== 1 || last_byte !== 8'hAA || last_err !== 2'b00) begin
            bad++;
            $display("FAIL aa_after_err: got n=%0d %h/%b want 1 aa/00", rdy_cnt - n0, last_byte, last_err);
        end
    endtask

    task automatic test_timeout;
        int n0 = rdy_cnt;
        send_bits(mk_frame(8'h0F, 1'b0, 1'b1), 0, 5);
        tick(TMO + 100);
        total++;
        if (rdy_cnt - n0 !== 0) begin
            bad++;
            $display("FAIL timeout_no_ready: got %0d pulses want 0", rdy_cnt - n0);
        end
        total++;
        if (bus.BYTE_READ !== 8'hAA || bus.BYTE_ERROR_CODE !== 2'b00) begin
            bad++;
            $display("FAIL timeout_hold: got %h/%b want aa/00", bus.BYTE_READ, bus.BYTE_ERROR_CODE);
        end
`ifdef MOUSE_RX_ERR_COUNT_EN
        total++;
        if (bus.ERROR_COUNT !== 8'h03) begin
            bad++;
            $display("FAIL timeout_errcnt: got %h want 03", bus.ERROR_COUNT);
        end
`endif
        n0 = rdy_cnt;
        send_bits(mk_frame(8'hFA, 1'b1, 1'b1), 0, 11);
        tick(20);
        total++;
        if (rdy_cnt - n0 !== 1 || last_byte !== 8'hFA || last_err !== 2'b00) begin
            bad++;
            $display("FAIL fa_after_timeout: got n=%0d %h/%b want 1 fa/00", rdy_cnt - n0, last_byte, last_err);
        end
    endtask

    task automatic test_reset_midframe;
        int n0 = rdy_cnt;
        send_bits(mk_frame(8'hFF, 1'b1, 1'b1), 0, 5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        send_bits(mk_frame(8'h55, 1'b1, 1'b1), 0, 11);
        tick(20);
        total++;
        if (rdy_cnt - n0 !== 1 || last_byte !== 8'h55 || last_err !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_55: got n=%0d %h/%b want 1 55/00", rdy_cnt - n0, last_byte, last_err);
        end
`ifdef MOUSE_RX_ERR_COUNT_EN
        total++;
        if (bus.ERROR_COUNT !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_errcnt: got %h want 00", bus.ERROR_COUNT);
        end
`endif
    endtask

    task automatic test_read_enable;
        int n0 = rdy_cnt;
        bus.READ_ENABLE = 1'b0;
        send_bits(mk_frame(8'h12, 1'b1, 1'b1), 0, 11);
        tick(TMO + 20);
        total++;
        if (rdy_cnt - n0 !== 0 || bus.BYTE_READ !== 8'h55) begin
            bad++;
            $display("FAIL re_low_12: got n=%0d byte=%h want 0 55", rdy_cnt - n0, bus.BYTE_READ);
        end
        bus.READ_ENABLE = 1'b1;
        n0 = rdy_cnt;
        send_bits(mk_frame(8'h34, 1'b0, 1'b1), 0, 11);
        tick(20);
        total++;
        if (rdy_cnt - n0 !== 1 || last_byte !== 8'h34 || last_err !== 2'b00) begin
            bad++;
            $display("FAIL re_high_34: got n=%0d %h/%b want 1 34/00", rdy_cnt - n0, last_byte, last_err);
        end
    endtask

    task automatic test_re_drop_midframe;
        int n0 = rdy_cnt;
        logic [10:0] f;
        f = mk_frame(8'hC3, 1'b1, 1'b1);
        send_bits(f, 0, 1);
        bus.READ_ENABLE = 1'b0;
        send_bits(f, 1, 10);
        tick(20);
        bus.READ_ENABLE = 1'b1;
        total++;
        if (rdy_cnt - n0 !== 1 || last_byte !== 8'hC3 || last_err !== 2'b00) begin
            bad++;
            $display("FAIL re_drop_c3: got n=%0d %h/%b want 1 c3/00", rdy_cnt - n0, last_byte, last_err);
        end
    endtask

    initial begin
        bus.CLK_MOUSE_IN  = 1'b1;
        bus.DATA_MOUSE_IN = 1'b1;
        bus.READ_ENABLE   = 1'b1;
        test_reset();
        test_basic();
        test_parity_error();
        test_stop_error();
        test_timeout();
        test_reset_midframe();
        test_read_enable();
        test_re_drop_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mouse_receiver.md
Name: mouse_receiver

Overview:
PS/2 device-to-host receive path for the mouse driver, and the counterpart to the host-to-device transmitter on the same open-collector CLK/DATA lines. It samples the mouse-driven clock and data lines and deframes 11-bit frames: start, 8 data bits LSB first, odd parity, stop. It presents each byte with error flags and a one-cycle strobe to the mouse master state machine.

Parameters:
TIMEOUT_CYCLES, 50000, number of CLK cycles with no PS/2 clock falling edge before a partial frame is abandoned (0.5 ms at 100 MHz).
CTR_WIDTH, 16, width of the timeout counter; must satisfy 2^CTR_WIDTH > TIMEOUT_CYCLES.

Ports:
CLK  input  1  system clock, 100 MHz.
RESET  input  1  synchronous, active-high reset.
CLK_MOUSE_IN  input  1  PS/2 clock line as seen at the pad (asynchronous).
DATA_MOUSE_IN  input  1  PS/2 data line as seen at the pad (asynchronous).
READ_ENABLE  input  1  high allows a new frame to start; low ignores start bits while idle.
BYTE_READ  output  8  last received data byte; holds until the next completed frame.
BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error; valid with BYTE_READY.
BYTE_READY  output  1  one-cycle strobe when a full frame has been received.

Behaviour:
- One clock domain (CLK). RESET is synchronous and active-high; it is sampled only on the rising edge of CLK.
- Reset values: BYTE_READ = 0x00, BYTE_ERROR_CODE = 00, BYTE_READY = 0, state = IDLE, bit counter = 0, timeout counter = 0.
- Synchronisation: CLK_MOUSE_IN and DATA_MOUSE_IN each pass through two flops before use.
- Edge detection: a third flop on the synchronised clock gives the previous value; fall = prev & ~cur. This is one CLK pulse per PS/2 falling edge. Data is sampled (synchronised value) only on fall.
- States:
  - IDLE: on fall with data = 0 and READ_ENABLE = 1, go to DATA and clear the bit counter. A fall with data = 1, or with READ_ENABLE = 0, is ignored.
  - DATA: on each fall, shift the sampled bit into shift[bitctr] (LSB first) and increment the counter. On the 8th bit (bitctr = 7), go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, go to DONE with stop = sampled data.
  - DONE: one cycle only. BYTE_READ <= shift; BYTE_ERROR_CODE[0] <= (^{shift, parity} != 1); BYTE_ERROR_CODE[1] <= ~stop; BYTE_READY = 1; go to IDLE.
- Errored bytes are still delivered (BYTE_READY = 1); the consumer decides what to do with them.
- Latency: BYTE_READY rises exactly 2 CLK cycles after the fall pulse of the stop bit (STOP->DONE registered, then outputs registered in DONE). Equivalently, 4-5 CLK cycles after the pad edge.
- Timeout: the counter clears on every fall and in IDLE, and otherwise increments in DATA/PARITY/STOP. When it reaches TIMEOUT_CYCLES-1, go to IDLE with no BYTE_READY, and BYTE_READ/BYTE_ERROR_CODE unchanged. The counter saturates; it never wraps.
- READ_ENABLE deasserted mid-frame: the frame completes normally. READ_ENABLE is only checked at the start bit.
- RESET mid-frame: return to IDLE next cycle and drop the partial frame. The following fall is treated as a possible start bit.
- Simultaneous fall and timeout terminal count in the same cycle: the fall wins (frame continues, counter clears).
- The block never drives the bus; this path is input-only.

Optional Feature:
Macro MOUSE_RX_ERR_COUNT_EN.
- Defined: adds output ERROR_COUNT[7:0], reset to 0. It increments by 1 on each BYTE_READY with BYTE_ERROR_CODE != 00, and on each timeout abort. It saturates at 0xFF. It is a debug aid for the seven-segment display.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package mouse_pkg holds:
  - the state encoding (IDLE, DATA, PARITY, STOP, DONE as 3-bit localparams);
  - error code constants ERR_NONE = 2'b00, ERR_PARITY = 2'b01, ERR_STOP = 2'b10;
  - PS2_FRAME_DATA_BITS = 8;
  - the default TIMEOUT_CYCLES.
- The transmitter reuses the same package.
- One natural sub-module is ps2_sync_edge: 2-flop synchroniser plus falling-edge pulse, one instance per line. Only the clock instance uses the edge output.

Test Plan:
- Frame for 0xFA (parity bit 1, stop 1), PS/2 period 80 us, READ_ENABLE = 1 -> one BYTE_READY pulse, BYTE_READ = 0xFA, BYTE_ERROR_CODE = 00.
- Frame for 0x08 with parity bit 1 (correct value is 0) -> BYTE_READ = 0x08, BYTE_ERROR_CODE = 01, BYTE_READY pulses once.
- Frame for 0x00 with parity 1 but stop bit 0 -> BYTE_ERROR_CODE = 10. Next valid 0xAA frame -> BYTE_READ = 0xAA, BYTE_ERROR_CODE = 00.
- Start plus 4 data bits, then the clock held high for 600 us -> no BYTE_READY, and BYTE_READ keeps its previous value. A subsequent 0xFA frame is received correctly.
- RESET pulsed for 1 cycle after the 5th bit, then a full 0x55 frame -> exactly one BYTE_READY with 0x55, error 00. With MOUSE_RX_ERR_COUNT_EN, ERROR_COUNT = 0.
- READ_ENABLE = 0 through a full 0x12 frame -> no BYTE_READY. Raising READ_ENABLE and sending 0x34 -> BYTE_READ = 0x34.
